sev_seg_capture: RTL

- Receive-side counterpart of the seven-segment driver: watches the multiplexed anode/seg/dp scan lines and recovers the four displayed characters.
- Outputs use the driver's 5-bit per-digit input format.
- Used for on-board loopback self-check and for bench scoreboarding of the display path.
- Sits beside the driver on the 50 MHz clock domain; the scan lines are treated as asynchronous inputs.

---
 rtl/sev_seg_capture.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sev_seg_capture.sv
// sev_seg_capture: recovers the four characters shown on a multiplexed
// seven-segment display by watching its anode/seg/dp scan lines.
// Each digit is captured once per anode activation, after its lines have
// been stable for SETTLE_CYCLES samples. The output uses the driver's
// 5-bit {dp, nibble} format.
module sev_seg_capture #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       dp,
    input  logic [3:0] anode,
    output logic [4:0] data_digit0,
    output logic [4:0] data_digit1,
    output logic [4:0] data_digit2,
    output logic [4:0] data_digit3,
    output logic [3:0] bad_pattern,
    output logic       frame_done,
    output logic       scan_timeout
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    // Synchronised line vector {anode, dp, seg} and its previous-cycle copy.
    logic [11:0]    sync1, sync2, v_prev;
    logic [3:0]     v_anode;
    logic           is_single;

    state_t         state, state_n;
    logic [SCW-1:0] stable_cnt, stable_cnt_n;
    logic [3:0]     held_anode, held_anode_n;
    logic           capture;

    logic [3:0]     cap_sel;
    logic [3:0]     cap_nib;
    logic           cap_bad;
    logic [3:0]     seen, seen_or;
    logic [CNT_W-1:0] tcnt;
    logic [4:0]     digit_q [4];

    assign v_anode   = sync2[11:8];
    assign is_single = $onehot(~v_anode);

    // Two-stage synchroniser; resets to the idle line levels (all high).
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            v_prev <= '1;
        end else begin
            sync1  <= {anode, dp, seg};
            sync2  <= sync1;
            v_prev <= sync2;
        end
    end

    // FSM state, stability counter and the anode of the held digit.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state      <= IDLE;
            stable_cnt <= '0;
            held_anode <= '1;
        end else begin
            state      <= state_n;
            stable_cnt <= stable_cnt_n;
            held_anode <= held_anode_n;
        end
    end

    // Next-state logic; capture fires the cycle after the SETTLE_CYCLES-th
    // identical sample, taking that sample from v_prev.
    always_comb begin
        state_n      = state;
        stable_cnt_n = stable_cnt;
        held_anode_n = held_anode;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (is_single) begin
                    state_n      = SETTLE;
                    stable_cnt_n = SCW'(1);
                end
            end
            SETTLE: begin
                if (stable_cnt == SCW'(SETTLE_CYCLES)) begin
                    capture      = 1'b1;
                    state_n      = HOLD;
                    held_anode_n = v_prev[11:8];
                end else if (!is_single) begin
                    state_n      = IDLE;
                    stable_cnt_n = '0;
                end else if (sync2 == v_prev) begin
                    stable_cnt_n = stable_cnt + SCW'(1);
                end else begin
                    stable_cnt_n = SCW'(1);
                end
            end
            HOLD: begin
                if (v_anode != held_anode) begin
                    if (is_single) begin
                        state_n      = SETTLE;
                        stable_cnt_n = SCW'(1);
                    end else begin
                        state_n      = IDLE;
                        stable_cnt_n = '0;
                    end
                end
            end
            default: begin
                state_n      = IDLE;
                stable_cnt_n = '0;
            end
        endcase
    end

    // Glyph decode of the captured segment pattern and frame mask update.
    always_comb begin
        cap_sel = ~v_prev[11:8];
        seen_or = seen | cap_sel;
        cap_bad = 1'b0;
        case (v_prev[6:0])
            7'h40: cap_nib = 4'h0;
            7'h79: cap_nib = 4'h1;
            7'h24: cap_nib = 4'h2;
            7'h30: cap_nib = 4'h3;
            7'h19: cap_nib = 4'h4;
            7'h12: cap_nib = 4'h5;
            7'h02: cap_nib = 4'h6;
            7'h78: cap_nib = 4'h7;
            7'h00: cap_nib = 4'h8;
            7'h10: cap_nib = 4'h9;
            7'h08: cap_nib = 4'hA;
            7'h03: cap_nib = 4'hB;
            7'h46: cap_nib = 4'hC;
            7'h21: cap_nib = 4'hD;
            7'h06: cap_nib = 4'hE;
            7'h0E: cap_nib = 4'hF;
            default: begin
                cap_nib = 4'h0;
                cap_bad = 1'b1;
            end
        endcase
    end

    // Captured digits, frame tracking and scan timeout; capture beats timeout.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++) digit_q[i] <= 5'h10;
            bad_pattern  <= '0;
            seen         <= '0;
            frame_done   <= 1'b0;
            tcnt         <= '0;
            scan_timeout <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (capture) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (cap_sel[i]) begin
                        digit_q[i]     <= {v_prev[7], cap_nib};
                        bad_pattern[i] <= cap_bad;
                    end
                end
                if (seen_or == 4'hF) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_or;
                end
                tcnt         <= '0;
                scan_timeout <= 1'b0;
            end else if (tcnt != CNT_W'(TIMEOUT_CYCLES)) begin
                tcnt <= tcnt + CNT_W'(1);
                if (tcnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    scan_timeout <= 1'b1;
                    seen         <= '0;
                end
            end
        end
    end

    assign data_digit0 = digit_q[0];
    assign data_digit1 = digit_q[1];
    assign data_digit2 = digit_q[2];
    assign data_digit3 = digit_q[3];

endmodule
